// File: rtl/stat_update_scheduler_if.sv
// Command channel from the stat update scheduler into the stats datapath.
// One saturating update is applied per cycle with cmd_valid && cmd_ready.
interface stat_update_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_idx;
  logic       cmd_inc;
  logic [1:0] cmd_amt;

  modport master (
    output cmd_valid,
    output cmd_idx,
    output cmd_inc,
    output cmd_amt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_idx,
    input  cmd_inc,
    input  cmd_amt,
    output cmd_ready
  );
endinterface

// File: rtl/stat_update_scheduler.sv
// Serialises periodic decay sweeps and player actions into one valid/ready
// command stream for the six pet-stat registers.
module stat_update_scheduler #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
  parameter logic [1:0]  ACT_AMT   = 2'd3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [5:0]                     action_req,
  input  logic [7:0]                     rnd,
  stat_update_scheduler_if.master        cmd,
  output logic [5:0]                     action_ack,
  output logic                           busy,
  output logic                           tick_overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACT,
    S_DECAY
  } state_t;

  localparam logic [23:0] LP_LAST     = MAX_COUNT - 24'd1;
  localparam logic [2:0]  LP_LAST_IDX = 3'd5;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [23:0] r_cnt;
  logic        w_tick;
  logic        r_tick_pend;
  logic        r_overrun;
  logic [5:0]  r_pend;
  logic [2:0]  r_rr;

  logic        r_cmd_valid;
  logic [2:0]  r_cmd_idx;
  logic        r_cmd_inc;
  logic [1:0]  r_cmd_amt;
  logic [5:0]  r_ack;

  logic        w_valid_nxt;
  logic [2:0]  w_idx_nxt;
  logic        w_inc_nxt;
  logic [1:0]  w_amt_nxt;
  logic [2:0]  w_rr_nxt;
  logic [5:0]  w_ack_nxt;
  logic [5:0]  w_pend_clr;
  logic        w_tick_take;

  logic        w_accept;
  logic        w_any_pend;
  logic [2:0]  w_sel;
  logic [2:0]  w_k_nxt;
  logic        w_rnd_unused;

  function automatic logic [5:0] idx_onehot(input logic [2:0] idx);
    return 6'd1 << idx;
  endfunction

  function automatic logic [2:0] idx_wrap_inc(input logic [2:0] idx);
    return (idx == LP_LAST_IDX) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic logic [1:0] decay_amt(input logic rbit);
    return rbit ? 2'd2 : 2'd1;
  endfunction

  // First set pending bit at or above ptr, wrapping modulo 6.
  function automatic logic [2:0] rr_pick(input logic [5:0] pend, input logic [2:0] ptr);
    logic [2:0] sel;
    logic [3:0] pos;
    sel = ptr;
    for (int j = 5; j >= 0; j--) begin
      pos = {1'b0, ptr} + 4'(j);
      if (pos >= 4'd6) pos = pos - 4'd6;
      if (pend[pos[2:0]]) sel = pos[2:0];
    end
    return sel;
  endfunction

  assign w_accept     = r_cmd_valid & cmd.cmd_ready;
  assign w_any_pend   = |r_pend;
  assign w_sel        = rr_pick(r_pend, r_rr);
  assign w_k_nxt      = r_cmd_idx + 3'd1;
  assign w_tick       = enable && (r_cnt == LP_LAST);
  assign w_rnd_unused = ^rnd[7:6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_tick ? 24'd0 : r_cnt + 24'd1;
    end
  end

  // A tick landing on an unserviced tick is dropped; only one sweep is owed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_pend <= 1'b0;
      r_overrun   <= 1'b0;
      r_pend      <= '0;
    end else begin
      r_tick_pend <= (r_tick_pend & ~w_tick_take) | w_tick;
      r_overrun   <= w_tick & r_tick_pend & ~w_tick_take;
      r_pend      <= (r_pend & ~w_pend_clr) | action_req;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_cmd_valid;
    w_idx_nxt   = r_cmd_idx;
    w_inc_nxt   = r_cmd_inc;
    w_amt_nxt   = r_cmd_amt;
    w_rr_nxt    = r_rr;
    w_ack_nxt   = '0;
    w_pend_clr  = '0;
    w_tick_take = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable) begin
          if (r_tick_pend) begin
            w_state_nxt = S_DECAY;
            w_tick_take = 1'b1;
            w_valid_nxt = 1'b1;
            w_idx_nxt   = 3'd0;
            w_inc_nxt   = 1'b0;
            w_amt_nxt   = decay_amt(rnd[0]);
          end else if (w_any_pend) begin
            w_state_nxt = S_ACT;
            w_valid_nxt = 1'b1;
            w_idx_nxt   = w_sel;
            w_inc_nxt   = 1'b1;
            w_amt_nxt   = ACT_AMT;
          end
        end
      end
      S_ACT: begin
        if (w_accept) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_ack_nxt   = idx_onehot(r_cmd_idx);
          w_pend_clr  = idx_onehot(r_cmd_idx);
          w_rr_nxt    = idx_wrap_inc(r_cmd_idx);
        end
      end
      S_DECAY: begin
        if (w_accept) begin
          if (r_cmd_idx == LP_LAST_IDX) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
          end else begin
            w_idx_nxt = w_k_nxt;
            w_amt_nxt = decay_amt(rnd[w_k_nxt]);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Command fields are registered together with the state so a new command
  // appears the cycle the state is entered and holds until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_idx   <= '0;
      r_cmd_inc   <= 1'b0;
      r_cmd_amt   <= '0;
      r_rr        <= '0;
      r_ack       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_valid <= w_valid_nxt;
      r_cmd_idx   <= w_idx_nxt;
      r_cmd_inc   <= w_inc_nxt;
      r_cmd_amt   <= w_amt_nxt;
      r_rr        <= w_rr_nxt;
      r_ack       <= w_ack_nxt;
    end
  end

  assign cmd.cmd_valid = r_cmd_valid;
  assign cmd.cmd_idx   = r_cmd_idx;
  assign cmd.cmd_inc   = r_cmd_inc;
  assign cmd.cmd_amt   = r_cmd_amt;
  assign action_ack    = r_ack;
  assign busy          = (r_state != S_IDLE);
  assign tick_overrun  = r_overrun;

  a_cmd_hold: assert property (@(posedge clk) disable iff (rst)
    (r_cmd_valid && !cmd.cmd_ready) |=>
      (r_cmd_valid && $stable(r_cmd_idx) && $stable(r_cmd_inc) && $stable(r_cmd_amt)));

  a_idx_range: assert property (@(posedge clk) disable iff (rst)
    r_cmd_valid |-> (r_cmd_idx <= LP_LAST_IDX));

endmodule
